regfile_mp: RTL

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/mips_rf_pkg.sv | 17 +
 rtl/rf_scoreboard.sv | 56 +++++
 rtl/regfile_mp.sv | 97 +++++++++
 3 files changed

// File: rtl/mips_rf_pkg.sv
// Shared constants for the multi-port register file and its scoreboard.
//   DEF_DATA_W / DEF_NUM_REGS : default data width and register count
//   WR_HIGH_PORT_WINS         : on same-address writes the higher port index wins
package mips_rf_pkg;

  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_NUM_REGS = 32;

  localparam bit WR_HIGH_PORT_WINS = 1'b1;

  // Visiting order of write ports; the last port visited has priority.
  function automatic int unsigned wr_port_order(input int unsigned step,
                                                input int unsigned nr_wr);
    return WR_HIGH_PORT_WINS ? step : (nr_wr - 1 - step);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by issue, cleared by write.
//   clk, rst_n : clock, async active-low reset
//   iss_valid  : issue reserving iss_addr as a destination
//   iss_addr   : destination register of the issue
//   wr_act     : per write port, write is active (enabled and address non-zero)
//   wr_addr    : per write port address
//   rd_addr    : per read port address
//   rd_busy    : per read port, addressed register still awaits its producer
module rf_scoreboard
  import mips_rf_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned NR_RD    = 2,
  parameter int unsigned NR_WR    = 1,
  localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          iss_valid,
  input  logic [ADDR_W-1:0]             iss_addr,
  input  logic [NR_WR-1:0]              wr_act,
  input  logic [NR_WR-1:0][ADDR_W-1:0]  wr_addr,
  input  logic [NR_RD-1:0][ADDR_W-1:0]  rd_addr,
  output logic [NR_RD-1:0]              rd_busy
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_next;

  // Pending state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_next;
  end

  // Clear on write first, then set on issue so a new producer wins.
  always_comb begin
    pending_next = pending;
    for (int unsigned p = 0; p < NR_WR; p++) begin
      if (wr_act[p]) pending_next[wr_addr[p]] = 1'b0;
    end
    if (iss_valid && (iss_addr != '0)) pending_next[iss_addr] = 1'b1;
  end

  // Busy lookup; a write landing this cycle already satisfies the reader.
  always_comb begin
    rd_busy = '0;
    for (int unsigned i = 0; i < NR_RD; i++) begin
      rd_busy[i] = pending[rd_addr[i]];
      for (int unsigned p = 0; p < NR_WR; p++) begin
        if (wr_act[p] && (wr_addr[p] == rd_addr[i])) rd_busy[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-through bypass and pending-write scoreboard.
//   clk, rst_n : clock, async active-low reset
//   rd_addr    : NR_RD read addresses; rd_data/rd_busy are combinational
//   wr_en      : NR_WR write strobes with wr_addr / wr_data
//   iss_valid  : issue reserving iss_addr (sets its pending bit next edge)
//   dbg_data   : contents of register DBG_ADDR, bypass included
module regfile_mp
  import mips_rf_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned NR_RD    = 2,
  parameter int unsigned NR_WR    = 1,
  parameter int unsigned DBG_ADDR = 16,
  localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NR_RD-1:0][ADDR_W-1:0]  rd_addr,
  output logic [NR_RD-1:0][DATA_W-1:0]  rd_data,
  output logic [NR_RD-1:0]              rd_busy,
  input  logic [NR_WR-1:0]              wr_en,
  input  logic [NR_WR-1:0][ADDR_W-1:0]  wr_addr,
  input  logic [NR_WR-1:0][DATA_W-1:0]  wr_data,
  input  logic                          iss_valid,
  input  logic [ADDR_W-1:0]             iss_addr,
  output logic [DATA_W-1:0]             dbg_data
);

  // Read lookups: the NR_RD ports plus the debug mirror in the last slot.
  localparam int unsigned NR_LK = NR_RD + 1;

  logic [DATA_W-1:0]              mem [NUM_REGS];
  logic [NR_WR-1:0]               wr_act;
  logic [NR_LK-1:0][ADDR_W-1:0]   lk_addr;
  logic [NR_LK-1:0][DATA_W-1:0]   lk_data;

  // Register 0 is never written, so it stays at its reset value of zero.
  always_comb begin
    wr_act = '0;
    for (int unsigned p = 0; p < NR_WR; p++) begin
      wr_act[p] = wr_en[p] && (wr_addr[p] != '0);
    end
  end

  // Storage; later ports in priority order overwrite earlier ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) mem[r] <= '0;
    end else begin
      for (int unsigned s = 0; s < NR_WR; s++) begin
        if (wr_act[wr_port_order(s, NR_WR)]) begin
          mem[wr_addr[wr_port_order(s, NR_WR)]] <= wr_data[wr_port_order(s, NR_WR)];
        end
      end
    end
  end

  always_comb begin
    lk_addr = '0;
    for (int unsigned i = 0; i < NR_RD; i++) lk_addr[i] = rd_addr[i];
    lk_addr[NR_RD] = ADDR_W'(DBG_ADDR);
  end

  // Combinational read with write-through bypass, same priority as storage.
  always_comb begin
    lk_data = '0;
    for (int unsigned i = 0; i < NR_LK; i++) begin
      lk_data[i] = mem[lk_addr[i]];
      for (int unsigned s = 0; s < NR_WR; s++) begin
        if (wr_act[wr_port_order(s, NR_WR)] &&
            (wr_addr[wr_port_order(s, NR_WR)] == lk_addr[i])) begin
          lk_data[i] = wr_data[wr_port_order(s, NR_WR)];
        end
      end
    end
  end

  assign rd_data  = lk_data[NR_RD-1:0];
  assign dbg_data = lk_data[NR_RD];

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NR_RD    (NR_RD),
    .NR_WR    (NR_WR)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .wr_act    (wr_act),
    .wr_addr   (wr_addr),
    .rd_addr   (rd_addr),
    .rd_busy   (rd_busy)
  );

endmodule
